// File: rtl/multicycle_seq_ctrl_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer (master)
// and the datapath/memory side (slave).
interface multicycle_seq_ctrl_if;
  logic        run;
  logic [31:0] instr_code;
  logic        btaken;
  logic        dmem_ack;
  logic        ir_en;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        reg_wr_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        retire;
  logic        illegal;
  logic        mem_err;
  logic [2:0]  state_o;

  modport master (
    input  run, instr_code, btaken, dmem_ack,
    output ir_en, pc_en, pc_sel, reg_wr_en, dmem_req, dmem_we,
           retire, illegal, mem_err, state_o
  );

  modport slave (
    output run, instr_code, btaken, dmem_ack,
    input  ir_en, pc_en, pc_sel, reg_wr_en, dmem_req, dmem_we,
           retire, illegal, mem_err, state_o
  );
endinterface

// File: rtl/multicycle_seq_ctrl.sv
// Moore sequencer for the multi-cycle RV32I datapath: decides when the
// IR, PC, register file and data memory see their per-stage strobes.
module multicycle_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5
  } state_t;

  localparam logic [6:0] OP_NOP   = 7'h00;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
      default:                                               writes_rd = 1'b0;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic       taken_q, taken_d;
  logic       aborted_q, aborted_d;
  logic [7:0] cnt_q, cnt_d;
  logic       unused_instr_hi;

  assign unused_instr_hi = ^bus.instr_code[31:7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      taken_q   <= 1'b0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      taken_q   <= taken_d;
      aborted_q <= aborted_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    taken_d   = taken_q;
    aborted_d = aborted_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // Unsupported opcodes collapse to a NOP class: PC+4, no write.
        op_d      = is_legal(bus.instr_code[6:0]) ? bus.instr_code[6:0] : OP_NOP;
        taken_d   = 1'b0;
        aborted_d = 1'b0;
        state_d   = S_EXECUTE;
      end
      S_EXECUTE: begin
        taken_d = (op_q == OP_BR) && bus.btaken;
        if (op_q == OP_LOAD || op_q == OP_STORE) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // Ack wins over a timeout landing on the same cycle.
        if (bus.dmem_ack) begin
          state_d = S_WB;
        end else if (cnt_q >= CNT_LAST) begin
          aborted_d = 1'b1;
          state_d   = S_WB;
        end
      end
      S_WB:     state_d = bus.run ? S_FETCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes decode registered state; illegal reads the already-loaded IR.
  assign bus.state_o   = state_q;
  assign bus.ir_en     = (state_q == S_FETCH);
  assign bus.pc_en     = (state_q == S_WB);
  assign bus.retire    = (state_q == S_WB);
  assign bus.reg_wr_en = (state_q == S_WB) && writes_rd(op_q) && !aborted_q;
  assign bus.mem_err   = (state_q == S_WB) && aborted_q;
  assign bus.dmem_req  = (state_q == S_MEM);
  assign bus.dmem_we   = (state_q == S_MEM) && (op_q == OP_STORE);
  assign bus.illegal   = (state_q == S_DECODE) && !is_legal(bus.instr_code[6:0]);

  always_comb begin
    bus.pc_sel = 2'd0;
    if (state_q == S_WB) begin
      if (op_q == OP_JALR)
        bus.pc_sel = 2'd2;
      else if (op_q == OP_JAL || (op_q == OP_BR && taken_q))
        bus.pc_sel = 2'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Directed bench for multicycle_seq_ctrl: walks one instruction of each
// class through the sequencer and checks every strobe cycle by cycle.
module tb_multicycle_seq_ctrl;

  logic clk;
  logic reset_n;
  int   total;
  int   passed;

  multicycle_seq_ctrl_if bus ();

  multicycle_seq_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ir_en, pc_en, pc_sel, reg_wr_en, dmem_req, dmem_we, retire, illegal, mem_err, state}
  function automatic logic [12:0] mk(input logic [2:0] st, input logic ir, input logic pc,
                                     input logic [1:0] sel, input logic wr, input logic req,
                                     input logic we, input logic ret, input logic ill,
                                     input logic err);
    mk = {ir, pc, sel, wr, req, we, ret, ill, err, st};
  endfunction

  function automatic logic [12:0] obs();
    obs = {bus.ir_en, bus.pc_en, bus.pc_sel, bus.reg_wr_en, bus.dmem_req, bus.dmem_we,
           bus.retire, bus.illegal, bus.mem_err, bus.state_o};
  endfunction

  task automatic chk(input string tag, input logic [12:0] exp);
    logic [12:0] o;
    o = obs();
    total++;
    assert (o === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [12:0] V_IDLE = 13'h0000;

  logic [12:0] v_fetch, v_dec, v_ex, v_mld, v_mst;

  initial begin
    total   = 0;
    passed  = 0;
    v_fetch = mk(3'd1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    v_dec   = mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    v_ex    = mk(3'd3, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    v_mld   = mk(3'd4, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0);
    v_mst   = mk(3'd4, 0, 0, 2'd0, 0, 1, 1, 0, 0, 0);

    reset_n         = 1'b0;
    bus.run         = 1'b0;
    bus.instr_code  = 32'h00100093;
    bus.btaken      = 1'b0;
    bus.dmem_ack    = 1'b0;
    tick(); tick();
    chk("reset_state", V_IDLE);

    reset_n = 1'b1;
    tick(); tick();
    chk("idle_run0", V_IDLE);

    // addi x1,x0,1
    bus.run = 1'b1;
    tick(); chk("addi_fetch", v_fetch);
    tick(); chk("addi_decode", v_dec);
    tick(); chk("addi_exec", v_ex);
    tick(); chk("addi_wb", mk(3'd5, 0, 1, 2'd0, 1, 0, 0, 1, 0, 0));

    // beq taken
    bus.instr_code = 32'h00000063;
    bus.btaken     = 1'b1;
    tick(); chk("beqt_fetch", v_fetch);
    tick(); chk("beqt_decode", v_dec);
    tick(); chk("beqt_exec", v_ex);
    tick(); chk("beqt_wb", mk(3'd5, 0, 1, 2'd1, 0, 0, 0, 1, 0, 0));

    // beq not taken
    bus.btaken = 1'b0;
    tick(); chk("beqn_fetch", v_fetch);
    tick(); tick(); tick();
    chk("beqn_wb", mk(3'd5, 0, 1, 2'd0, 0, 0, 0, 1, 0, 0));

    // jalr, with a stray ack in DECODE that must be ignored
    bus.instr_code = 32'h00008067;
    tick(); chk("jalr_fetch", v_fetch);
    bus.dmem_ack = 1'b1;
    tick(); chk("jalr_decode", v_dec);
    bus.dmem_ack = 1'b0;
    tick(); chk("jalr_exec", v_ex);
    tick(); chk("jalr_wb", mk(3'd5, 0, 1, 2'd2, 1, 0, 0, 1, 0, 0));

    // lw, ack on 3rd MEM cycle: retire on cycle 7 from FETCH
    bus.instr_code = 32'h00002083;
    tick(); chk("lw_fetch", v_fetch);
    tick(); chk("lw_decode", v_dec);
    tick(); chk("lw_exec", v_ex);
    tick(); chk("lw_mem1", v_mld);
    tick(); chk("lw_mem2", v_mld);
    tick(); chk("lw_mem3", v_mld);
    bus.dmem_ack = 1'b1;
    tick(); chk("lw_wb", mk(3'd5, 0, 1, 2'd0, 1, 0, 0, 1, 0, 0));
    bus.dmem_ack = 1'b0;

    // sw with no ack: 15 MEM cycles then aborted WB
    bus.instr_code = 32'h00112023;
    tick(); chk("sw_fetch", v_fetch);
    tick(); tick();
    chk("sw_exec", v_ex);
    for (int i = 0; i < 15; i++) begin
      tick(); chk($sformatf("sw_mem%0d", i + 1), v_mst);
    end
    tick(); chk("sw_timeout_wb", mk(3'd5, 0, 1, 2'd0, 0, 0, 0, 1, 0, 1));

    // unsupported opcode, then park in IDLE
    bus.instr_code = 32'h0000007F;
    tick(); chk("ill_fetch", v_fetch);
    tick(); chk("ill_decode", mk(3'd2, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0));
    tick(); chk("ill_exec", v_ex);
    bus.run = 1'b0;
    tick(); chk("ill_wb", mk(3'd5, 0, 1, 2'd0, 0, 0, 0, 1, 0, 0));
    tick(); chk("park_idle", V_IDLE);
    tick(); chk("park_idle2", V_IDLE);

    // lw with ack on the last timeout cycle: success, not abort
    bus.instr_code = 32'h00002083;
    bus.run        = 1'b1;
    tick(); chk("lwe_fetch", v_fetch);
    tick(); tick(); tick();
    chk("lwe_mem1", v_mld);
    for (int i = 1; i < 15; i++) tick();
    chk("lwe_mem15", v_mld);
    bus.dmem_ack = 1'b1;
    tick(); chk("lwe_wb", mk(3'd5, 0, 1, 2'd0, 1, 0, 0, 1, 0, 0));
    bus.dmem_ack = 1'b0;

    // reset asserted mid-MEM clears outputs immediately
    tick(); chk("lwr_fetch", v_fetch);
    tick(); tick(); tick();
    chk("lwr_mem1", v_mld);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", V_IDLE);
    bus.run = 1'b0;
    tick(); chk("reset_hold", V_IDLE);
    #2 reset_n = 1'b1;
    tick(); chk("release_run0", V_IDLE);
    bus.run = 1'b1;
    tick(); chk("release_fetch", v_fetch);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
